// File: rtl/cpu_pkg.sv
// Shared EX-stage types: the buffered result entry and the skid-buffer state encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wb_en;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } ex_result_t;

endpackage

// File: rtl/ex_flag_gen.sv
// Combinational Z/N/C/V flag generation from the adder outputs.
module ex_flag_gen (
    input  logic [31:0] sum,
    input  logic        cout,
    input  logic        overflow,
    input  logic        op_sub,
    input  logic        op_signed,
    output logic        z,
    output logic        n,
    output logic        c,
    output logic        v
);

    always_comb begin
        z = (sum == '0);
        n = sum[31];
        // Subtraction reports borrow, which is the inverted adder carry.
        c = op_sub ? ~cout : cout;
        v = overflow & op_signed;
    end

endmodule

// File: rtl/ex_result_stage.sv
// EX result stage: 2-entry skid buffer with flag capture and sticky overflow trap.
// Optional feature: define EX_OVF_TRAP_EN to enable the overflow trap and writeback suppression.
module ex_result_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sum,
    input  logic        cout,
    input  logic        overflow,
    input  logic        op_sub,
    input  logic        op_signed,
    input  logic [4:0]  rd,
    input  logic        wb_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c,
    output logic        flag_v,
    output logic        trap,
    input  logic        trap_ack
);

    skid_state_t state, state_next;
    ex_result_t  head, skid, cap;
    logic        fz, fn, fc, fv;
    logic        in_xfer, out_xfer;

    ex_flag_gen u_flag_gen (
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .op_sub    (op_sub),
        .op_signed (op_signed),
        .z         (fz),
        .n         (fn),
        .c         (fc),
        .v         (fv)
    );

    // Handshakes decode only the state register, so in_ready never sees out_ready.
    assign in_ready  = (state != SKID_FULL);
    assign out_valid = (state != SKID_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        cap        = '0;
        cap.result = sum;
        cap.rd     = rd;
        cap.z      = fz;
        cap.n      = fn;
        cap.c      = fc;
        cap.v      = fv;
`ifdef EX_OVF_TRAP_EN
        cap.wb_en  = wb_en & ~fv;
`else
        cap.wb_en  = wb_en;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            SKID_EMPTY: if (in_xfer) state_next = SKID_ONE;
            SKID_ONE: begin
                if (in_xfer && !out_xfer)      state_next = SKID_FULL;
                else if (!in_xfer && out_xfer) state_next = SKID_EMPTY;
            end
            SKID_FULL:  if (out_xfer) state_next = SKID_ONE;
            default:    state_next = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SKID_EMPTY;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            case (state)
                SKID_EMPTY: if (in_xfer) head <= cap;
                SKID_ONE: begin
                    if (in_xfer && out_xfer) head <= cap;
                    else if (in_xfer)        skid <= cap;
                end
                SKID_FULL:  if (out_xfer) head <= skid;
                default:    ;
            endcase
        end
    end

    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wb_en  = head.wb_en;
    assign flag_z     = head.z;
    assign flag_n     = head.n;
    assign flag_c     = head.c;
    assign flag_v     = head.v;

`ifdef EX_OVF_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (reset)                trap_q <= 1'b0;
        else if (in_xfer && cap.v) trap_q <= 1'b1;
        else if (trap_ack)        trap_q <= 1'b0;
    end

    assign trap = trap_q;
`else
    logic unused_trap_ack;
    assign unused_trap_ack = trap_ack;
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed and scoreboard-checked bench for ex_result_stage (honours EX_OVF_TRAP_EN).
module tb_ex_result_stage;

`ifdef EX_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, cout, overflow, op_sub, op_signed, wb_en;
    logic [31:0] sum, out_result;
    logic [4:0]  rd, out_rd;
    logic        out_valid, out_ready, out_wb_en;
    logic        flag_z, flag_n, flag_c, flag_v, trap, trap_ack;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    ex_result_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum        (sum),
        .cout       (cout),
        .overflow   (overflow),
        .op_sub     (op_sub),
        .op_signed  (op_signed),
        .rd         (rd),
        .wb_en      (wb_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wb_en  (out_wb_en),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .trap       (trap),
        .trap_ack   (trap_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic co, input logic ov,
                         input logic sub, input logic sgn, input logic [4:0] r, input logic we);
        in_valid  = v;
        sum       = s;
        cout      = co;
        overflow  = ov;
        op_sub    = sub;
        op_signed = sgn;
        rd        = r;
        wb_en     = we;
    endtask

    logic [39:0] q[$];
    logic [39:0] exp_e;
    logic [41:0] prev_out;
    logic        prev_stall, in_x, out_x;

    initial begin
        reset = 1'b1; out_ready = 1'b0; trap_ack = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    out_result, 0);
        check("rst_rd_wb",     {out_rd, out_wb_en}, 0);
        check("rst_flags",     {flag_z, flag_n, flag_c, flag_v}, 0);
        check("rst_trap",      trap, 0);

        // Zero result on subtract: Z set, borrow = ~cout = 0
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
        tick();
        check("zero_valid", out_valid, 1);
        check("zero_zc",    {flag_z, flag_c, flag_n, flag_v}, 4'b1000);
        check("zero_rd_wb", {out_rd, out_wb_en}, {5'd3, 1'b1});
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("zero_drain", out_valid, 0);

        // Signed overflow
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
        tick();
        check("ovf_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
        check("ovf_trap",  trap, TRAP_EN);
        check("ovf_wb",    out_wb_en, !TRAP_EN);
        // Another overflowing capture with trap_ack in the same cycle: set wins
        trap_ack = 1'b1;
        tick();
        check("set_wins_trap", trap, TRAP_EN);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("ack_clears", trap, 0);
        check("ovf_drain",  out_valid, 0);
        trap_ack = 1'b0;

        // Same stimulus on an unsigned op: no V, no trap, writeback kept
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1);
        tick();
        check("uns_flags", {flag_n, flag_v}, 2'b10);
        check("uns_trap",  trap, 0);
        check("uns_wb",    out_wb_en, 1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();

        // Stall, fill both entries, then release in order
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
        tick();
        check("fill1_ready", in_ready, 1);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        check("full_ready",  in_ready, 0);
        check("full_head",   {out_valid, out_result, out_rd}, {1'b1, 32'h11, 5'd1});
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        tick();
        check("full_hold",   {out_valid, out_result, out_rd, in_ready}, {1'b1, 32'h11, 5'd1, 1'b0});
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("rel_second",  {out_valid, out_result, out_rd}, {1'b1, 32'h22, 5'd2});
        check("rel_ready",   in_ready, 1);
        tick();
        check("rel_empty",   out_valid, 0);

        // Reset while FULL discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
        tick(); tick();
        check("pre_rst_full", in_ready, 0);
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        reset = 1'b0;
        check("midrst_state", {out_valid, in_ready, trap}, 3'b010);
        check("midrst_data",  out_result, 0);

        // Random traffic against a FIFO scoreboard
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            if (prev_stall)
                check("stall_hold", {out_valid, out_result, out_rd, out_wb_en, flag_z, flag_n, flag_c}, prev_out);
            check("model_hs", {in_ready, out_valid}, {q.size() < 2, q.size() != 0});
            drive($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0 ? 32'h0 : $urandom(),
                  $urandom_range(1, 0) == 1, 1'b0, $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1, 5'($urandom()), $urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(2, 0) != 0);
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (out_x) begin
                if (q.size() == 0) begin
                    check("underflow", 1, 0);
                end else begin
                    exp_e = q.pop_front();
                    check("order", {out_result, out_rd, out_wb_en, flag_z, flag_n}, exp_e);
                end
            end
            if (in_x) q.push_back({sum, rd, wb_en, sum == 32'h0, sum[31]});
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_result, out_rd, out_wb_en, flag_z, flag_n, flag_c};
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        out_ready = 1'b1;
        while (q.size() != 0 && out_valid) begin
            exp_e = q.pop_front();
            check("drain", {out_result, out_rd, out_wb_en, flag_z, flag_n}, exp_e);
            tick();
        end
        check("drain_empty", {out_valid, q.size() == 0}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
